// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive engines.
//   tx_state_e    : transmit engine state encoding
//   START_BIT     : line level of a start bit
//   STOP_BIT      : line level of a stop bit, also the idle level
//   DIV_WIDTH_DEF : default width of the baud divisor
//   DATA_WIDTH_DEF: default number of data bits per frame
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int DIV_WIDTH_DEF  = 16;
   localparam int DATA_WIDTH_DEF = 8;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LOAD   = 3'd2,
      START  = 3'd3,
      DATA   = 3'd4,
      PARITY = 3'd5,
      STOP   = 3'd6
   } tx_state_e;

endpackage : uart_pkg

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
// Loadable bit-period down-counter. A load captures the reload value (bit
// period minus one) and starts the count from it; while enabled the counter
// decrements and, on reaching zero, raises tick_o for that cycle and reloads.
//
// Ports
//   clk_i        in   system clock
//   rstn_i       in   asynchronous active-low reset
//   load_i       in   capture load_val_i as the new period and restart
//   load_val_i   in   WIDTH  bit period minus one
//   en_i         in   count enable
//   tick_o       out  last cycle of the current bit period
//   zero_next_o  out  the count will be zero in the next cycle, so a tick
//                     is due next cycle if the counter stays enabled
// -----------------------------------------------------------------------------
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   output logic             tick_o,
   output logic             zero_next_o
);

   logic [WIDTH-1:0] period_q, period_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             cnt_zero;

   assign cnt_zero = (cnt_q == '0);

   always_comb begin
      cnt_d    = cnt_q;
      period_d = period_q;
      if (load_i) begin
         cnt_d    = load_val_i;
         period_d = load_val_i;
      end else if (en_i) begin
         cnt_d = cnt_zero ? period_q : (cnt_q - WIDTH'(1));
      end
   end

   assign tick_o      = en_i && cnt_zero;
   assign zero_next_o = (cnt_d == '0);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q    <= '0;
         period_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         period_q <= period_d;
      end
   end

endmodule : uart_baud_cnt

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// UART transmit engine. Pulls one byte at a time from the TX FIFO read port
// and sends it as start bit, LSB-first data, optional parity, one stop bit.
// Bit period is max(baud_div_i, 1) clocks, captured at the start of each
// frame so divisor changes only affect following frames.
//
// Build option: UART_TX_PARITY_EN
//   defined   -> a parity bit follows the data (even, or odd when
//                parity_odd_i=1, captured per frame)
//   undefined -> 8N1 frames, parity_odd_i is ignored
//
// Ports
//   clk_i           in   system clock (shared with the FIFO)
//   rstn_i          in   asynchronous active-low reset
//   tx_en_i         in   transmitter enable
//   baud_div_i      in   DIV_WIDTH   clocks per bit, 0 behaves as 1
//   parity_odd_i    in   odd (1) / even (0) parity select
//   fifo_empty_i    in   TX FIFO empty flag
//   fifo_rd_data_i  in   DATA_WIDTH  FIFO data, valid the cycle after rden
//   fifo_rden_o     out  single-cycle FIFO read pulse per byte (registered)
//   tx_o            out  serial line, idles high (registered)
//   busy_o          out  engine not idle
//   done_o          out  pulse in the last cycle of each stop bit (registered)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line high, waiting for enable and a non-empty FIFO
// FETCH  | FIFO read enable asserted for this one cycle
// LOAD   | capture FIFO data, bit period and parity; reset bit counter
// START  | start bit (low) for one bit period
// DATA   | data bits LSB-first, one bit period each
// PARITY | parity bit for one bit period (parity builds only)
// STOP   | stop bit (high); chains straight to FETCH if more data waits
// -----------------------------------------------------------------------------
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DIV_WIDTH  = DIV_WIDTH_DEF
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  tx_en_i,
   input  logic [DIV_WIDTH-1:0]  baud_div_i,
   input  logic                  parity_odd_i,
   input  logic                  fifo_empty_i,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
   output logic                  fifo_rden_o,
   output logic                  tx_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

   tx_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic                  tx_q, tx_d;
   logic                  rden_q, rden_d;
   logic                  done_q, done_d;
   logic                  more_data;

   logic                  baud_load;
   logic                  baud_en;
   logic                  baud_tick;
   logic                  baud_zero_next;
   logic [DIV_WIDTH-1:0]  baud_reload;

`ifdef UART_TX_PARITY_EN
   logic                  parity_q, parity_d;
`else
   logic                  parity_odd_unused;
   assign parity_odd_unused = parity_odd_i;
`endif

   // Counter holds period-1; a zero divisor is clamped to a 1-clock period.
   assign baud_reload = (baud_div_i == '0) ? '0 : (baud_div_i - DIV_WIDTH'(1));
   assign baud_en     = (state_q == START) || (state_q == DATA) ||
                        (state_q == PARITY) || (state_q == STOP);
   assign more_data   = tx_en_i && !fifo_empty_i;

   uart_baud_cnt #(
      .WIDTH (DIV_WIDTH)
   ) u_baud_cnt (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .load_i      (baud_load),
      .load_val_i  (baud_reload),
      .en_i        (baud_en),
      .tick_o      (baud_tick),
      .zero_next_o (baud_zero_next)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      baud_load = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif

      case (state_q)
         IDLE: begin
            if (more_data) state_d = FETCH;
         end
         FETCH: begin
            state_d = LOAD;
         end
         LOAD: begin
            shift_d   = fifo_rd_data_i;
            bit_cnt_d = '0;
            baud_load = 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_d  = (^fifo_rd_data_i) ^ parity_odd_i;
`endif
            state_d   = START;
         end
         START: begin
            if (baud_tick) state_d = DATA;
         end
         DATA: begin
            if (baud_tick) begin
               if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                  shift_d   = shift_q >> 1;
               end
            end
         end
         PARITY: begin
`ifdef UART_TX_PARITY_EN
            if (baud_tick) state_d = STOP;
`else
            state_d = IDLE;
`endif
         end
         STOP: begin
            if (baud_tick) state_d = more_data ? FETCH : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they leave the flops
      // aligned with the state they belong to.
      tx_d = STOP_BIT;
      case (state_d)
         START:   tx_d = START_BIT;
         DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = parity_d;
`endif
         default: tx_d = STOP_BIT;
      endcase

      rden_d = (state_d == FETCH);
      done_d = (state_d == STOP) && baud_zero_next;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= STOP_BIT;
         rden_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         rden_q    <= rden_d;
         done_q    <= done_d;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) parity_q <= 1'b0;
      else         parity_q <= parity_d;
   end
`endif

   assign tx_o        = tx_q;
   assign fifo_rden_o = rden_q;
   assign done_o      = done_q;
   assign busy_o      = (state_q != IDLE);

endmodule : uart_tx_serializer
